// File: rtl/cpu_pkg.sv
// Shared types and widths for the CPU front end.
package cpu_pkg;

  localparam int INST_W = 18;
  localparam int ADDR_W = 12;

  typedef logic [INST_W-1:0] inst_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK
  } fetch_state_t;

  function automatic addr_t sext_disp(input logic [7:0] disp);
    return {{(ADDR_W - 8){disp[7]}}, disp};
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC arithmetic: sequential increment and redirect target selection.
module pc_next
  import cpu_pkg::*;
(
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic [ADDR_W-1:0] branch_base,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              branch,
  input  logic [7:0]        disp,
  output logic [ADDR_W-1:0] seq_pc,
  output logic              redir,
  output logic [ADDR_W-1:0] redir_target
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    seq_pc       = fetch_addr + addr_t'(1);
    redir        = jump | branch;
    redir_target = branch_base + sext_disp(disp);
    if (jump) begin
      redir_target = jump_addr;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: PC, memory strobe/ack handshake, redirects and timeout.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 12'h000,
  parameter int                MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              branch_i,
  input  logic [7:0]        disp_i,
  output logic              mem_stb_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [INST_W-1:0] mem_data_i,
  output logic [INST_W-1:0] inst_o,
  output logic              ack_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              err_o
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  fetch_state_t state, next_state;

  addr_t      pc;
  addr_t      pend_target;
  logic       pend_valid;
  logic [7:0] wait_cnt;

  addr_t seq_pc;
  addr_t branch_base;
  addr_t redir_target;
  addr_t pc_eff;
  addr_t redir_pc;
  logic  redir;
  logic  start;
  logic  timeout;

  assign start   = en_i && !stall_i;
  assign timeout = !mem_ack_i && (wait_cnt == WAIT_LAST);

  // While a request is outstanding, pc still names the fetched word, so the
  // branch base must be the word after it.
  assign branch_base = (state == REQ) ? seq_pc : pc;
  assign pc_eff      = redir ? redir_target : pc;
  assign redir_pc    = redir ? redir_target : pend_target;

  pc_next u_pc_next (
    .fetch_addr  (mem_addr_o),
    .branch_base (branch_base),
    .jump        (jump_i),
    .jump_addr   (jump_addr_i),
    .branch      (branch_i),
    .disp        (disp_i),
    .seq_pc      (seq_pc),
    .redir       (redir),
    .redir_target(redir_target)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start) next_state = REQ;
      REQ: begin
        if (mem_ack_i) begin
          next_state = (redir || pend_valid) ? IDLE : ACK;
        end else if (timeout) begin
          next_state = IDLE;
        end
      end
      ACK:     next_state = start ? REQ : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_stb_o = (state == REQ);
    ack_o     = (state == ACK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      mem_addr_o  <= '0;
      inst_o      <= '0;
      pc_o        <= '0;
      err_o       <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      wait_cnt    <= '0;
    end else begin
      err_o <= 1'b0;
      if (state == REQ) begin
        if (mem_ack_i) begin
          wait_cnt   <= '0;
          pend_valid <= 1'b0;
          if (redir || pend_valid) begin
            pc <= redir_pc;
          end else begin
            inst_o <= mem_data_i;
            pc_o   <= mem_addr_o;
            pc     <= seq_pc;
          end
        end else if (timeout) begin
          err_o      <= 1'b1;
          wait_cnt   <= '0;
          pend_valid <= 1'b0;
          // A redirect raised during the dead request still wins over the retry.
          if (redir || pend_valid) begin
            pc <= redir_pc;
          end
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
          if (redir) begin
            pend_valid  <= 1'b1;
            pend_target <= redir_target;
          end
        end
      end else begin
        pc         <= pc_eff;
        mem_addr_o <= pc_eff;
        wait_cnt   <= '0;
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed phases push expected requests and deliveries.
module tb_inst_fetch;
  import cpu_pkg::*;

  typedef struct {
    logic [17:0] inst;
    logic [11:0] pc;
  } exp_ack_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        jump_i = 1'b0;
  logic [11:0] jump_addr_i = '0;
  logic        branch_i = 1'b0;
  logic [7:0]  disp_i = '0;
  logic        mem_stb_o;
  logic [11:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [17:0] mem_data_i = '0;
  logic [17:0] inst_o;
  logic        ack_o;
  logic [11:0] pc_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  int ack_seen = 0;
  int err_seen = 0;
  int stb_len = 0;
  int last_len = 0;
  int ack_delay = 0;
  int mcnt = 0;
  logic mute = 1'b0;
  logic stb_prev = 1'b0;
  logic err_prev = 1'b0;
  logic [11:0] cur_req = '0;

  logic [11:0] req_q[$];
  exp_ack_t    ack_q[$];
  exp_ack_t    e;

  inst_fetch #(.RESET_PC(12'h010), .MAX_WAIT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en_i),
    .stall_i    (stall_i),
    .jump_i     (jump_i),
    .jump_addr_i(jump_addr_i),
    .branch_i   (branch_i),
    .disp_i     (disp_i),
    .mem_stb_o  (mem_stb_o),
    .mem_addr_o (mem_addr_o),
    .mem_ack_i  (mem_ack_i),
    .mem_data_i (mem_data_i),
    .inst_o     (inst_o),
    .ack_o      (ack_o),
    .pc_o       (pc_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_fetch(input logic [11:0] addr);
    exp_ack_t x;
    x.inst = 18'(addr) + 18'h100;
    x.pc   = addr;
    req_q.push_back(addr);
    ack_q.push_back(x);
  endtask

  task automatic wait_acks(input int n);
    int target;
    target = ack_seen + n;
    for (int i = 0; i < 200 && ack_seen < target; i++) begin
      @(negedge clk);
      #1;
    end
    if (ack_seen < target) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: saw %0d deliveries, required %0d", ack_seen, target);
    end
  endtask

  // Memory model: answers a strobe after ack_delay cycles unless muted.
  always @(posedge clk) begin
    #1;
    if (mem_stb_o) begin
      mem_ack_i  = (mcnt == ack_delay) && !mute;
      mem_data_i = 18'(mem_addr_o) + 18'h100;
      mcnt++;
    end else begin
      mem_ack_i = 1'b0;
      mcnt      = 0;
    end
  end

  // Monitor: compares requests, deliveries and error pulses against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_stb_o && !stb_prev) begin
        stb_len = 1;
        if (req_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected: addr %h, none required", mem_addr_o);
        end else begin
          cur_req = req_q.pop_front();
          check("req_addr", 32'(mem_addr_o), 32'(cur_req));
        end
      end else if (mem_stb_o) begin
        stb_len++;
        check("req_addr_stable", 32'(mem_addr_o), 32'(cur_req));
      end else if (stb_prev) begin
        last_len = stb_len;
      end
      if (ack_o) begin
        ack_seen++;
        if (ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ack_unexpected: inst %h pc %h, no delivery required", inst_o, pc_o);
        end else begin
          e = ack_q.pop_front();
          check("ack_inst", 32'(inst_o), 32'(e.inst));
          check("ack_pc", 32'(pc_o), 32'(e.pc));
        end
      end
      if (err_o) begin
        err_seen++;
        check("err_single", 32'(err_prev), 32'd0);
        check("err_stb_low", 32'(mem_stb_o), 32'd0);
      end
    end
    stb_prev = mem_stb_o;
    err_prev = err_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_stb", 32'(mem_stb_o), 32'd0);
    check("rst_addr", 32'(mem_addr_o), 32'd0);
    check("rst_inst", 32'(inst_o), 32'd0);
    check("rst_pc", 32'(pc_o), 32'd0);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);

    // Zero-wait streaming from RESET_PC.
    for (int i = 0; i < 4; i++) expect_fetch(12'h010 + 12'(i));
    en_i = 1'b1;
    step();
    rst_n = 1'b1;
    wait_acks(4);
    en_i = 1'b0;

    // Jump applied in IDLE on the start cycle, then wrap past 12'hFFF.
    step();
    jump_i = 1'b1;
    jump_addr_i = 12'hFFE;
    en_i = 1'b1;
    expect_fetch(12'hFFE);
    expect_fetch(12'hFFF);
    expect_fetch(12'h000);
    step();
    jump_i = 1'b0;
    wait_acks(3);
    en_i = 1'b0;

    // Three-cycle memory latency: strobe held four cycles.
    step();
    ack_delay = 3;
    en_i = 1'b1;
    expect_fetch(12'h001);
    wait_acks(1);
    en_i = 1'b0;
    check("slow_stb_len", 32'(last_len), 32'd4);
    ack_delay = 0;

    // Branch during an outstanding request at 12'h020: data dropped, refetch at 12'h01D.
    step();
    ack_delay = 2;
    jump_i = 1'b1;
    jump_addr_i = 12'h020;
    en_i = 1'b1;
    req_q.push_back(12'h020);
    step();
    jump_i = 1'b0;
    en_i = 1'b0;
    branch_i = 1'b1;
    disp_i = 8'hFC;
    step();
    branch_i = 1'b0;
    repeat (6) step();
    ack_delay = 0;
    en_i = 1'b1;
    expect_fetch(12'h01D);
    wait_acks(1);
    en_i = 1'b0;

    // Jump and branch together, coinciding with mem_ack_i: jump wins, data dropped.
    step();
    ack_delay = 1;
    en_i = 1'b1;
    req_q.push_back(12'h01E);
    step();
    en_i = 1'b0;
    step();
    jump_i = 1'b1;
    jump_addr_i = 12'h300;
    branch_i = 1'b1;
    disp_i = 8'h05;
    step();
    jump_i = 1'b0;
    branch_i = 1'b0;
    repeat (4) step();
    ack_delay = 0;
    en_i = 1'b1;
    expect_fetch(12'h300);
    wait_acks(1);
    en_i = 1'b0;

    // Stall raised during ACK: delivery still happens, no new strobe until release.
    step();
    en_i = 1'b1;
    expect_fetch(12'h301);
    wait_acks(1);
    stall_i = 1'b1;
    repeat (4) step();
    expect_fetch(12'h302);
    stall_i = 1'b0;
    wait_acks(1);
    en_i = 1'b0;

    // Memory never answers: timeout after 15 cycles, same address retried.
    step();
    mute = 1'b1;
    en_i = 1'b1;
    req_q.push_back(12'h303);
    expect_fetch(12'h303);
    for (int i = 0; i < 100 && err_seen == 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("timeout_err_seen", 32'(err_seen), 32'd1);
    check("timeout_stb_len", 32'(last_len), 32'd15);
    mute = 1'b0;
    wait_acks(1);
    en_i = 1'b0;

    // Asynchronous reset in the middle of a request.
    step();
    mute = 1'b1;
    en_i = 1'b1;
    req_q.push_back(12'h304);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("midrst_stb", 32'(mem_stb_o), 32'd0);
    check("midrst_addr", 32'(mem_addr_o), 32'd0);
    check("midrst_inst", 32'(inst_o), 32'd0);
    check("midrst_pc", 32'(pc_o), 32'd0);
    check("midrst_ack", 32'(ack_o), 32'd0);
    check("midrst_err", 32'(err_o), 32'd0);
    step();
    en_i = 1'b0;
    mute = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    en_i = 1'b1;
    expect_fetch(12'h010);
    wait_acks(1);
    en_i = 1'b0;
    repeat (3) step();

    check("req_queue_empty", 32'(req_q.size()), 32'd0);
    check("ack_queue_empty", 32'(ack_q.size()), 32'd0);
    check("err_total", 32'(err_seen), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction fetch unit; the producer side of the instruction register's load handshake.
- Holds the 12-bit program counter.
- Issues read requests to instruction memory over a strobe/ack handshake.
- Delivers each fetched 18-bit instruction to the instruction register as inst_o with a one-cycle ack_o pulse.
- Handles jump and branch redirects, decode stalls, and memory timeouts.

Parameters:
RESET_PC, 12'h000, PC value loaded on reset.
MAX_WAIT, 15, cycles a request may stay unacknowledged before a timeout (range 1..255).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
en_i  in  1  run enable; no new request is started while low
stall_i  in  1  downstream stall; no new request is started while high
jump_i  in  1  absolute redirect request, single-cycle pulse
jump_addr_i  in  12  absolute target address
branch_i  in  1  relative redirect request, single-cycle pulse
disp_i  in  8  signed displacement for branch_i
mem_stb_o  out  1  memory read request
mem_addr_o  out  12  memory read address
mem_ack_i  in  1  memory read acknowledge; data valid in the same cycle
mem_data_i  in  18  memory read data
inst_o  out  18  fetched instruction, held until the next delivery
ack_o  out  1  one-cycle "inst_o valid, load it" pulse to the instruction register
pc_o  out  12  address of the instruction currently on inst_o
err_o  out  1  one-cycle pulse on memory timeout

Behaviour:
Reset (asynchronous on rst_n low):
- pc = RESET_PC, state = IDLE, inst_o = 0, pc_o = 0, mem_stb_o = 0, mem_addr_o = 0, ack_o = 0, err_o = 0, pending redirect cleared, wait counter = 0.
- Reset mid-request drops the request with no ack_o.

FSM states: IDLE, REQ, ACK.
- IDLE:
  - If en_i && !stall_i, go to REQ next cycle.
  - mem_addr_o is registered to the pc value in effect at that cycle (including any redirect applied that cycle).
- REQ:
  - mem_stb_o = 1; mem_addr_o is stable throughout.
  - Wait counter increments each cycle without mem_ack_i.
  - On mem_ack_i with no pending redirect: inst_o <= mem_data_i, pc_o <= mem_addr_o, pc <= mem_addr_o + 1 (mod 4096, 12'hFFF wraps to 12'h000). Go to ACK.
  - On mem_ack_i with a redirect pending: data is discarded, no ACK state, pc <= redirect target. Go to IDLE.
  - If the counter reaches MAX_WAIT with no ack: err_o pulses, stb drops, go to IDLE with pc unchanged so the fetch is retried.
- ACK:
  - ack_o = 1 for exactly this cycle. mem_stb_o = 0.
  - If en_i && !stall_i, go directly to REQ; otherwise go to IDLE.

Throughput and latency:
- Zero-wait memory: 1 instruction per 2 cycles.
- Request to ack_o: 1 cycle after mem_ack_i.

Redirects:
- Sampled every cycle.
- Target: jump gives jump_addr_i; branch gives pc + sign_extend(disp_i), mod 4096, where pc is the next-fetch address.
- jump_i has priority when jump_i and branch_i coincide.
- In IDLE or ACK: pc is updated that cycle.
- In REQ: the target is latched as pending; a later redirect overwrites the pending target.
- A redirect in the same cycle as mem_ack_i counts as pending, so that data is discarded.

stall_i and en_i only gate starting a request. They never abort an outstanding REQ or suppress an ack_o already due.

Decomposition:
- Shared package cpu_pkg:
  - INST_W = 18, ADDR_W = 12.
  - fetch_state_t enum {IDLE, REQ, ACK}.
  - Typedefs inst_t (logic [17:0]) and addr_t (logic [11:0]).
- Optional sub-module pc_next: combinational target select and adder covering pc+1, pc+sext(disp), and jump_addr, with priority. Everything else stays flat.

Test Plan:
- Reset with RESET_PC=12'h010, en_i=1, zero-wait memory returning data=addr+18'h100:
  - First mem_addr_o = 12'h010.
  - ack_o pulses every 2nd cycle with inst_o = 18'h110, 18'h111, ...
  - pc_o tracks 12'h010, 12'h011, ...
- pc at 12'hFFE, sequential fetch: addresses go 12'hFFE, 12'hFFF, then 12'h000; no X or carry leakage.
- mem_ack_i delayed 3 cycles: mem_stb_o and mem_addr_o stay constant for 4 cycles; a single ack_o follows.
- branch_i with disp_i=8'hFC while REQ at 12'h020 is outstanding:
  - The acked data is discarded and no ack_o is issued.
  - Next request address = 12'h021 - 4 = 12'h01D.
  - jump_i and branch_i together select jump_addr_i.
- stall_i high during ACK: ack_o still pulses once; no new mem_stb_o until stall_i falls; then the fetch resumes at the next pc.
- No mem_ack_i for MAX_WAIT=15 cycles:
  - err_o pulses once, stb drops, the same address is re-requested.
  - rst_n low mid-REQ clears all outputs asynchronously.
